// File: rtl/debug_hart_ctrl_pkg.sv
// Shared definitions for the hart-side debug controller: core configuration
// type, debug state encoding and the DCSR cause codes it reports.
package debug_hart_ctrl_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 32'd32};

    typedef enum logic [2:0] {
        ST_RUNNING   = 3'd0,
        ST_HALTING   = 3'd1,
        ST_HALTED    = 3'd2,
        ST_RESUMING  = 3'd3,
        ST_STEPPING  = 3'd4
    } dbg_state_e;

    // Cause codes as written into DCSR.cause; trigger (2) is never produced.
    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
    localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
    localparam logic [2:0] CAUSE_STEP      = 3'd4;
    localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

endpackage

// File: rtl/debug_hart_ctrl_cause_prio.sv
// Fixed-priority encoder choosing the debug entry cause:
// ebreak > resethaltreq > haltreq > step.
module debug_cause_prio
    import debug_hart_ctrl_pkg::*;
(
    input  logic       ebreak,
    input  logic       resethalt,
    input  logic       haltreq,
    input  logic       step,
    output logic [2:0] cause
);

    // Highest-priority active request wins; no request reports CAUSE_NONE.
    always_comb begin
        cause = CAUSE_NONE;
        if (ebreak) begin
            cause = CAUSE_EBREAK;
        end else if (resethalt) begin
            cause = CAUSE_RESETHALT;
        end else if (haltreq) begin
            cause = CAUSE_HALTREQ;
        end else if (step) begin
            cause = CAUSE_STEP;
        end else begin
            cause = CAUSE_NONE;
        end
    end

endmodule

// File: rtl/debug_hart_ctrl.sv
// Hart-side debug state machine: decides when the core enters and leaves
// Debug Mode and drives the entry strobe, cause and pipeline controls
// consumed by the debug CSR block.
module debug_hart_ctrl
    import debug_hart_ctrl_pkg::*;
#(
    parameter cvw_t P = CVW_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       HaltReq,
    input  logic       ResumeReq,
    input  logic       ResetHaltReq,
    input  logic       AckHaveReset,
    input  logic       ebreakM,
    input  logic       ebreakEn,
    input  logic       Step,
    input  logic       InstrValidM,
    input  logic       StallM,
    output logic       DCall,
    output logic [2:0] DebugCause,
    output logic       DebugMode,
    output logic       DebugFlushM,
    output logic       DRet,
    output logic       DebugStallF,
    output logic       DebugIntMask,
    output logic       Halted,
    output logic       Running,
    output logic       ResumeAck,
    output logic       HaveReset
);

    // No XLEN-wide datapath lives here; only RV32/RV64 configurations apply.
    if ((P.XLEN != 32'd32) && (P.XLEN != 32'd64)) begin : g_xlen_unsupported
    end

    dbg_state_e state_r, state_next;
    logic [2:0] cause_r, cause_next;
    logic       step_done_r, step_done_next;
    logic       have_reset_r;
    logic       ebreak_hit_s;
    logic       boundary_s;
    logic       dcall_s;
    logic       flush_s;
    logic       dcall_out_s;
    logic [2:0] prio_cause_s;

    assign ebreak_hit_s = ebreakM & ebreakEn & ~StallM;
    assign boundary_s   = InstrValidM & ~StallM;

    debug_cause_prio u_cause_prio (
        .ebreak    (ebreak_hit_s),
        .resethalt (cause_r == CAUSE_RESETHALT),
        .haltreq   (cause_r == CAUSE_HALTREQ),
        .step      (state_r == ST_STEPPING),
        .cause     (prio_cause_s)
    );

    // State, latched halt cause and step progress; reset may land in HALTING.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ResetHaltReq ? ST_HALTING : ST_RUNNING;
            cause_r     <= ResetHaltReq ? CAUSE_RESETHALT : CAUSE_NONE;
            step_done_r <= 1'b0;
        end else begin
            state_r     <= state_next;
            cause_r     <= cause_next;
            step_done_r <= step_done_next;
        end
    end

    // Sticky HaveReset: reset sets it and wins over a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            have_reset_r <= 1'b1;
        end else if (AckHaveReset) begin
            have_reset_r <= 1'b0;
        end else begin
            have_reset_r <= have_reset_r;
        end
    end

    // Next-state logic plus the M-stage entry strobe and flush decision.
    always_comb begin
        state_next     = state_r;
        cause_next     = cause_r;
        step_done_next = step_done_r;
        dcall_s        = 1'b0;
        flush_s        = 1'b0;
        case (state_r)
            ST_RUNNING: begin
                if (ebreak_hit_s) begin
                    // ebreak retires into debug: DPC is the ebreak PC.
                    dcall_s    = 1'b1;
                    state_next = ST_HALTED;
                end else if (HaltReq) begin
                    state_next = ST_HALTING;
                    cause_next = CAUSE_HALTREQ;
                end else begin
                    state_next = ST_RUNNING;
                end
            end
            ST_HALTING: begin
                if (ebreak_hit_s || boundary_s) begin
                    dcall_s    = 1'b1;
                    flush_s    = ~ebreak_hit_s;
                    state_next = ST_HALTED;
                end else begin
                    state_next = ST_HALTING;
                end
            end
            ST_HALTED: begin
                cause_next = CAUSE_NONE;
                if (ResumeReq && !HaltReq) begin
                    state_next = ST_RESUMING;
                end else begin
                    state_next = ST_HALTED;
                end
            end
            ST_RESUMING: begin
                cause_next     = CAUSE_NONE;
                step_done_next = 1'b0;
                state_next     = Step ? ST_STEPPING : ST_RUNNING;
            end
            ST_STEPPING: begin
                if (ebreak_hit_s) begin
                    dcall_s    = 1'b1;
                    state_next = ST_HALTED;
                end else if (boundary_s && step_done_r) begin
                    dcall_s    = 1'b1;
                    flush_s    = 1'b1;
                    state_next = ST_HALTED;
                end else begin
                    // The first boundary is the stepped instruction retiring.
                    step_done_next = step_done_r | boundary_s;
                    if (HaltReq) begin
                        cause_next = CAUSE_HALTREQ;
                    end else begin
                        cause_next = cause_r;
                    end
                end
            end
            default: begin
                state_next     = ST_RUNNING;
                cause_next     = CAUSE_NONE;
                step_done_next = 1'b0;
            end
        endcase
    end

    // No capture strobe while the block is being reset.
    assign dcall_out_s  = dcall_s & ~reset;
    assign DCall        = dcall_out_s;
    assign DebugCause   = dcall_out_s ? prio_cause_s : CAUSE_NONE;
    assign DebugFlushM  = flush_s & ~reset;

    assign DebugMode    = (state_r == ST_HALTED) | (state_r == ST_RESUMING);
    assign Halted       = (state_r == ST_HALTED);
    assign Running      = (state_r == ST_RUNNING) | (state_r == ST_STEPPING);
    assign DRet         = (state_r == ST_RESUMING);
    assign ResumeAck    = (state_r == ST_RESUMING);
    assign DebugStallF  = (state_r == ST_HALTING);
    assign DebugIntMask = (state_r == ST_STEPPING);
    assign HaveReset    = have_reset_r;

endmodule

// File: tb/tb_debug_hart_ctrl.sv
// Randomized scoreboard bench for debug_hart_ctrl. A behavioural model of the
// debug rules predicts every output each cycle; a monitor compares them.
module tb_debug_hart_ctrl;
    import debug_hart_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset, HaltReq, ResumeReq, ResetHaltReq, AckHaveReset;
    logic       ebreakM, ebreakEn, Step, InstrValidM, StallM;
    logic       DCall, DebugMode, DebugFlushM, DRet, DebugStallF, DebugIntMask;
    logic       Halted, Running, ResumeAck, HaveReset;
    logic [2:0] DebugCause;

    debug_hart_ctrl dut (
        .clk(clk), .reset(reset), .HaltReq(HaltReq), .ResumeReq(ResumeReq),
        .ResetHaltReq(ResetHaltReq), .AckHaveReset(AckHaveReset),
        .ebreakM(ebreakM), .ebreakEn(ebreakEn), .Step(Step),
        .InstrValidM(InstrValidM), .StallM(StallM), .DCall(DCall),
        .DebugCause(DebugCause), .DebugMode(DebugMode), .DebugFlushM(DebugFlushM),
        .DRet(DRet), .DebugStallF(DebugStallF), .DebugIntMask(DebugIntMask),
        .Halted(Halted), .Running(Running), .ResumeAck(ResumeAck),
        .HaveReset(HaveReset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dcall;
        logic [2:0] cause;
        logic       flush;
        logic       mode;
        logic       dret;
        logic       stallf;
        logic       intmask;
        logic       halted;
        logic       running;
        logic       ack;
        logic       have_reset;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   n_dcall  = 0;

    // Model of the debug rules, in terms of what the hart is doing.
    bit m_in_debug, m_resume, m_stepping, m_have_reset;
    int m_pend, m_retired;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever an expectation is queued, compare it mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                if (DCall === 1'b1) n_dcall++;
                check("DCall",        DCall,        mon_e.dcall);
                check("DebugCause",   DebugCause,   mon_e.cause);
                check("DebugFlushM",  DebugFlushM,  mon_e.flush);
                check("DebugMode",    DebugMode,    mon_e.mode);
                check("DRet",         DRet,         mon_e.dret);
                check("DebugStallF",  DebugStallF,  mon_e.stallf);
                check("DebugIntMask", DebugIntMask, mon_e.intmask);
                check("Halted",       Halted,       mon_e.halted);
                check("Running",      Running,      mon_e.running);
                check("ResumeAck",    ResumeAck,    mon_e.ack);
                check("HaveReset",    HaveReset,    mon_e.have_reset);
            end
        end
    end

    // Driver: random stimulus, model prediction pushed to the scoreboard.
    initial begin
        exp_t e;
        bit   ebk, bnd, halting, active, dc;
        reset = 1'b1; HaltReq = 1'b0; ResumeReq = 1'b0; ResetHaltReq = 1'b0;
        AckHaveReset = 1'b0; ebreakM = 1'b0; ebreakEn = 1'b0; Step = 1'b0;
        InstrValidM = 1'b0; StallM = 1'b0;
        m_in_debug = 1'b0; m_resume = 1'b0; m_stepping = 1'b0; m_have_reset = 1'b1;
        m_pend = 0; m_retired = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 3) begin
                // Power-up reset ends with a halt-on-reset request.
                reset        = 1'b1;
                ResetHaltReq = (cyc == 2);
                AckHaveReset = 1'b0;
            end else begin
                reset        = ($urandom_range(199) == 0);
                ResetHaltReq = ($urandom_range(1) == 1);
                AckHaveReset = reset ? ($urandom_range(1) == 1) : ($urandom_range(19) == 0);
            end
            HaltReq     = HaltReq ? ($urandom_range(9) != 0) : ($urandom_range(29) == 0);
            ResumeReq   = ($urandom_range(5) == 0);
            ebreakM     = ($urandom_range(24) == 0);
            ebreakEn    = ($urandom_range(3) != 0);
            Step        = ($urandom_range(1) == 1);
            InstrValidM = ($urandom_range(1) == 1);
            StallM      = ($urandom_range(2) == 0);

            ebk     = ebreakM && ebreakEn && !StallM;
            bnd     = InstrValidM && !StallM;
            active  = !m_in_debug && !m_resume;
            halting = active && (m_pend != 0) && !m_stepping;
            dc      = !reset && active &&
                      (ebk || (halting && bnd) || (m_stepping && bnd && m_retired >= 1));

            e.dcall      = dc;
            e.cause      = !dc ? 3'd0 : ebk ? 3'd1 : (m_pend != 0) ? 3'(m_pend) : 3'd4;
            e.flush      = dc && !ebk;
            e.mode       = m_in_debug || m_resume;
            e.dret       = m_resume;
            e.ack        = m_resume;
            e.stallf     = halting;
            e.intmask    = m_stepping;
            e.halted     = m_in_debug;
            e.running    = active && !halting;
            e.have_reset = m_have_reset;
            if (cyc >= 3) sb_q.push_back(e);

            if (reset) begin
                m_in_debug = 1'b0; m_resume = 1'b0; m_stepping = 1'b0; m_retired = 0;
                m_pend     = ResetHaltReq ? 5 : 0;
            end else if (dc) begin
                m_in_debug = 1'b1; m_pend = 0; m_stepping = 1'b0;
            end else if (m_in_debug) begin
                if (ResumeReq && !HaltReq) begin
                    m_in_debug = 1'b0; m_resume = 1'b1;
                end
            end else if (m_resume) begin
                m_resume = 1'b0; m_stepping = Step; m_retired = 0;
            end else if (m_stepping) begin
                if (bnd) m_retired++;
                if (HaltReq) m_pend = 3;
            end else if (m_pend == 0 && HaltReq) begin
                m_pend = 3;
            end
            if (reset) m_have_reset = 1'b1;
            else if (AckHaveReset) m_have_reset = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 3'(sb_q.size()), 3'd0);
        checks++;
        if (n_dcall == 0) begin
            failures++;
            $display("FAIL dcall_seen: actual=0 expected=nonzero debug entries");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
